// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared types and default widths for the immediate extender (IMMX_SHIFT_EN adds ovf)
package imm_pkg;

  localparam int IMM_IN_W  = 12;
  localparam int IMM_OUT_W = 16;
  localparam int IMM_W1    = 4;
  localparam int IMM_W2    = 8;
  localparam int IMM_W3    = 12;

  typedef enum logic [1:0] {
    NONE      = 2'b00,
    FOURBIT   = 2'b01,
    EIGHTBIT  = 2'b10,
    TWELVEBIT = 2'b11
  } sel_t;

  typedef struct packed {
    logic [IMM_OUT_W-1:0] value;
    logic                 neg;
`ifdef IMMX_SHIFT_EN
    logic                 ovf;
`endif
  } entry_t;

endpackage

// File: rtl/imm_fmt.sv
// rtl/imm_fmt.sv - combinational zero/sign extend of a selected immediate field (IMMX_SHIFT_EN adds shift)
module imm_fmt
  import imm_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W,
  parameter int OUT_W = IMM_OUT_W,
  parameter int W1    = IMM_W1,
  parameter int W2    = IMM_W2,
  parameter int W3    = IMM_W3
) (
  input  sel_t             sel,
  input  logic             zext,
  input  logic [IN_W-1:0]  value,
`ifdef IMMX_SHIFT_EN
  input  logic [1:0]       shl,
  output logic             ovf,
`endif
  output logic [OUT_W-1:0] result,
  output logic             neg
);

  logic [OUT_W-1:0] ext;

  always_comb begin
    ext = '0;
    case (sel)
      FOURBIT:   ext = {{(OUT_W-W1){~zext & value[W1-1]}}, value[W1-1:0]};
      EIGHTBIT:  ext = {{(OUT_W-W2){~zext & value[W2-1]}}, value[W2-1:0]};
      TWELVEBIT: ext = {{(OUT_W-W3){~zext & value[W3-1]}}, value[W3-1:0]};
      default:   ext = {{(OUT_W-IN_W){1'b0}}, value};
    endcase
  end

`ifdef IMMX_SHIFT_EN
  // Overflow when any bit shifted out disagrees with the sign of what remains.
  always_comb begin
    result = ext << shl;
    ovf    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ((i < int'(shl)) && (ext[OUT_W-1-i] != result[OUT_W-1])) ovf = 1'b1;
    end
  end
`else
  assign result = ext;
`endif

  assign neg = result[OUT_W-1];

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - immediate extender feeding a 2-entry valid/ready queue (IMMX_SHIFT_EN adds in_shl/out_ovf)
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int IN_W  = IMM_IN_W,
  parameter int OUT_W = IMM_OUT_W,
  parameter int W1    = IMM_W1,
  parameter int W2    = IMM_W2,
  parameter int W3    = IMM_W3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  sel_t             in_sel,
  input  logic             in_zext,
  input  logic [IN_W-1:0]  in_value,
`ifdef IMMX_SHIFT_EN
  input  logic [1:0]       in_shl,
  output logic             out_ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_value,
  output logic             out_neg
);

  typedef struct packed {
    logic [OUT_W-1:0] value;
    logic             neg;
`ifdef IMMX_SHIFT_EN
    logic             ovf;
`endif
  } slot_t;

  slot_t      mem [2];
  slot_t      fmt_entry;
  slot_t      head;
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push;
  logic       pop;

  imm_fmt #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .W1   (W1),
    .W2   (W2),
    .W3   (W3)
  ) u_fmt (
    .sel   (in_sel),
    .zext  (in_zext),
    .value (in_value),
`ifdef IMMX_SHIFT_EN
    .shl   (in_shl),
    .ovf   (fmt_entry.ovf),
`endif
    .result(fmt_entry.value),
    .neg   (fmt_entry.neg)
  );

  // Ready comes only from the registered count, so no path from out_ready to in_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= fmt_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign out_value = head.value;
  assign out_neg   = head.neg;
`ifdef IMMX_SHIFT_EN
  assign out_ovf   = head.ovf;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - directed self-checking bench for imm_extend_pipe
module tb_imm_extend_pipe;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  sel_t        in_sel;
  logic        in_zext;
  logic [11:0] in_value;
`ifdef IMMX_SHIFT_EN
  logic [1:0]  in_shl;
  logic        out_ovf;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_value;
  logic        out_neg;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imm_extend_pipe dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sel   (in_sel),
    .in_zext  (in_zext),
    .in_value (in_value),
`ifdef IMMX_SHIFT_EN
    .in_shl   (in_shl),
    .out_ovf  (out_ovf),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_value(out_value),
    .out_neg  (out_neg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input sel_t s, input logic z, input logic [11:0] val);
    in_valid = v;
    in_sel   = s;
    in_zext  = z;
    in_value = val;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
`ifdef IMMX_SHIFT_EN
    in_shl = 2'd0;
`endif
    drive(1'b0, NONE, 1'b0, 12'h000);
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_value", out_value, 16'h0000);
    check("rst_out_neg", out_neg, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    drive(1'b1, FOURBIT, 1'b0, 12'h00A);
    step();
    drive(1'b0, NONE, 1'b0, 12'h000);
    check("four_valid", out_valid, 1);
    check("four_value", out_value, 16'hFFFA);
    check("four_neg", out_neg, 1);
    step();
    check("four_drained", out_valid, 0);

    drive(1'b1, EIGHTBIT, 1'b0, 12'h07F);
    step();
    check("eight_7f", out_value, 16'h007F);
    check("eight_7f_neg", out_neg, 0);
    drive(1'b1, EIGHTBIT, 1'b0, 12'h080);
    step();
    check("eight_80", out_value, 16'hFF80);
    check("eight_80_neg", out_neg, 1);
    check("eight_80_valid", out_valid, 1);
    drive(1'b0, NONE, 1'b0, 12'h000);
    step();
    check("eight_drained", out_valid, 0);

    drive(1'b1, TWELVEBIT, 1'b1, 12'h800);
    step();
    check("twelve_zext", out_value, 16'h0800);
    check("twelve_zext_neg", out_neg, 0);
    drive(1'b1, TWELVEBIT, 1'b0, 12'h800);
    step();
    check("twelve_sext", out_value, 16'hF800);
    drive(1'b1, NONE, 1'b0, 12'hFFF);
    step();
    check("none_fff", out_value, 16'h0FFF);
    check("none_fff_neg", out_neg, 0);
    drive(1'b1, FOURBIT, 1'b0, 12'h0F7);
    step();
    check("four_upper_ignored", out_value, 16'h0007);
    drive(1'b1, EIGHTBIT, 1'b1, 12'hAFF);
    step();
    check("eight_zext", out_value, 16'h00FF);
    drive(1'b0, NONE, 1'b0, 12'h000);
    step();
    check("mix_drained", out_valid, 0);

    // Backpressure: two beats fit, the third waits.
    out_ready = 1'b0;
    drive(1'b1, EIGHTBIT, 1'b0, 12'h011);
    step();
    check("bp_ready_c1", in_ready, 1);
    drive(1'b1, EIGHTBIT, 1'b0, 12'h022);
    step();
    check("bp_ready_full", in_ready, 0);
    drive(1'b1, EIGHTBIT, 1'b0, 12'h033);
    step();
    check("bp_ready_held", in_ready, 0);
    check("bp_head_held", out_value, 16'h0011);
    out_ready = 1'b1;
    step();
    check("bp_second", out_value, 16'h0022);
    check("bp_ready_rise", in_ready, 1);
    step();
    drive(1'b0, NONE, 1'b0, 12'h000);
    check("bp_third", out_value, 16'h0033);
    check("bp_third_valid", out_valid, 1);
    step();
    check("bp_drained", out_valid, 0);

    // Flush while full with a beat offered.
    out_ready = 1'b0;
    drive(1'b1, EIGHTBIT, 1'b0, 12'h044);
    step();
    drive(1'b1, EIGHTBIT, 1'b0, 12'h055);
    step();
    drive(1'b1, EIGHTBIT, 1'b0, 12'h066);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, NONE, 1'b0, 12'h000);
    check("flush_full_valid", out_valid, 0);
    check("flush_full_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    check("flush_full_gone", out_valid, 0);

    // Flush with one entry and an acceptable push plus pop: flush wins both.
    drive(1'b1, EIGHTBIT, 1'b0, 12'h012);
    step();
    drive(1'b1, EIGHTBIT, 1'b0, 12'h034);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, NONE, 1'b0, 12'h000);
    check("flush_push_valid", out_valid, 0);
    step();
    check("flush_push_gone", out_valid, 0);
    drive(1'b1, EIGHTBIT, 1'b0, 12'h077);
    step();
    drive(1'b0, NONE, 1'b0, 12'h000);
    check("post_flush_value", out_value, 16'h0077);
    check("post_flush_valid", out_valid, 1);
    step();

    // Asynchronous reset mid-stream, observed between edges.
    out_ready = 1'b0;
    drive(1'b1, FOURBIT, 1'b0, 12'h008);
    step();
    drive(1'b1, FOURBIT, 1'b0, 12'h009);
    step();
    drive(1'b0, NONE, 1'b0, 12'h000);
    check("pre_rst_value", out_value, 16'hFFF8);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_ready", in_ready, 1);
    check("async_rst_value", out_value, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, TWELVEBIT, 1'b0, 12'h7FF);
    step();
    drive(1'b0, NONE, 1'b0, 12'h000);
    check("post_rst_value", out_value, 16'h07FF);
    check("post_rst_neg", out_neg, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
